usb_pkt_rx: RTL
===============

Name: usb_pkt_rx

Overview:
- Receive-side packet engine, the counterpart of the USB test transmitter.
- Takes a UTMI-style byte stream (rx_active/rx_valid/rx_data) and validates the PID.
- Strips and checks the CRC16 on DATA0/DATA1 packets, forwards payload bytes through a small FIFO with valid/ready handshake, and reports per-packet status.
- Sits between the PHY-side byte interface and the endpoint buffer logic.

Parameters:
- FIFO_DEPTH, 4, payload FIFO entries (power of 2, >=2)
- MAX_LEN, 64, maximum payload bytes per data packet, CRC bytes excluded

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- rx_active  input  1  high for the duration of a packet
- rx_valid  input  1  rx_data holds a byte this cycle; ignored while rx_active=0
- rx_data  input  8  received byte, PID byte first
- out_data  output  8  payload byte at FIFO head
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts out_data when out_valid=1
- pkt_done  output  1  one-cycle pulse at end of packet
- pkt_pid  output  4  PID[3:0] of the last packet
- pkt_len  output  10  payload bytes pushed for the last packet
- crc_ok  output  1  last packet passed its check
- err_pid  output  1  last packet had a bad PID
- err_len  output  1  last packet had a bad length
- err_ovf  output  1  last packet overflowed the FIFO

Behaviour:
- Reset (reset=0 at clk edge):
  - State IDLE; FIFO flushed; out_valid=0; pkt_done=0.
  - pkt_pid=0, pkt_len=0, crc_ok=0, all err_* = 0.
  - CRC register = 0xFFFF; rx_active_d register = 1.
- Start of packet: detected only on a rising edge of rx_active (rx_active=1, rx_active_d=0). A reset mid-packet therefore ignores the remainder of that packet.
- States:
  - IDLE: waits for start of packet, then goes to PID.
  - PID: the first valid byte b is checked.
    - b[3:0] != ~b[7:4] -> ERR with err_pid.
    - PID 0x3 (DATA0) or 0xB (DATA1) -> DATA; CRC=0xFFFF; count=0.
    - PID 0x2, 0xA, 0xE (ACK/NAK/STALL) -> HSK.
    - Any other valid PID -> ERR with err_pid.
  - DATA: uses a 2-byte delay line d0/d1 so the CRC bytes are never forwarded.
    - Every valid byte updates the CRC: LSB-first shift-right, poly 0xA001.
    - The first two bytes only fill the delay line.
    - Each later byte pushes the oldest delayed byte into the FIFO and increments count.
  - HSK: any further valid byte sets err_len.
  - ERR: all bytes are ignored until rx_active=0; nothing further is pushed.
  - DONE: entered from PID/DATA/HSK/ERR the cycle rx_active is sampled 0.
    - DONE asserts pkt_done for one cycle (cycle N+1 after rx_active low is sampled in cycle N), then returns to IDLE.
- Status at DONE; all status outputs are held until the next pkt_done.
  - DATA packets: crc_ok = (CRC==0xB001) && no err_*.
  - HSK packets: crc_ok = no err_*.
  - PID-state timeout (rx_active falls before any byte arrives) -> err_pid.
- err_len conditions:
  - data packet with fewer than 2 bytes after the PID;
  - count would exceed MAX_LEN; the offending byte is dropped and the packet goes to ERR.
- err_ovf: a push while the FIFO is full and out_ready=0. The byte is dropped and the packet goes to ERR.
  - A push while full with out_ready=1 and out_valid=1 is legal: pop and push occur in the same cycle.
- Bytes already pushed for an errored packet remain in the FIFO; the consumer discards them using the status outputs.
- The FIFO read side is independent of the packet FSM; out_data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- USB_RX_STATS_EN defined: adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - On each pkt_done, good_cnt increments if crc_ok=1, otherwise bad_cnt increments.
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package usb_rx_pkg holds:
  - PID constants (DATA0/DATA1/ACK/NAK/STALL);
  - the FSM state encoding (IDLE, PID, DATA, HSK, ERR, DONE);
  - CRC16_POLY=0xA001, CRC16_INIT=0xFFFF, CRC16_RESID=0xB001.
- One sub-module, usb_rx_fifo: synchronous FIFO, parameter FIFO_DEPTH, push/pop/full/empty, same reset.

Test Plan:
- DATA0 zero-length: C3 00 00 -> pkt_done 1 cycle after rx_active falls; pkt_pid=3, pkt_len=0, crc_ok=1, out_valid stays 0.
- Corrupt CRC: C3 00 01 -> crc_ok=0, no err_* set.
- Bad PID: C4 -> err_pid=1, crc_ok=0; a handshake D2 -> pkt_pid=2, pkt_len=0, crc_ok=1.
- Overflow: out_ready=0, 4B + 8 payload + 2 CRC bytes -> FIFO holds payload bytes 1-4, err_ovf=1 on the 5th push; draining yields exactly those 4 bytes in order.
- Length: MAX_LEN=4, C3 + 6 payload + CRC -> err_len=1, pkt_len=4; C3 + 1 byte -> err_len=1, pkt_len=0.
- Reset mid-packet: reset pulse during DATA, rx_active still high for 3 more bytes -> no push, no pkt_done. The next packet C3 00 00 is received correctly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared constants, FSM encoding and CRC16 helper for the USB receive packet engine.
package usb_rx_pkg;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [15:0] CRC16_POLY  = 16'hA001;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'hB001;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    DATA,
    HSK,
    ERR,
    DONE
  } rx_state_e;

  // Reflected CRC16: bytes enter LSB first, register shifts right.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC16_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_rx_fifo.sv
// Synchronous payload FIFO; a push while full is accepted only together with a pop.
module usb_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/usb_pkt_rx.sv
// USB receive packet engine: PID check, CRC16 strip/check, payload FIFO, per-packet status.
// Optional USB_RX_STATS_EN adds saturating good_cnt/bad_cnt packet counters.
module usb_pkt_rx
  import usb_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LEN    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_done,
  output logic [3:0] pkt_pid,
  output logic [9:0] pkt_len,
  output logic       crc_ok,
  output logic       err_pid,
  output logic       err_len,
  output logic       err_ovf
`ifdef USB_RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  rx_state_e   state;
  logic        rx_active_d;
  logic [15:0] crc;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [1:0]  fill;
  logic [9:0]  count;
  logic [3:0]  cur_pid;
  logic        e_pid;
  logic        e_len;
  logic        e_ovf;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic data_byte;
  logic len_hit;
  logic ovf_hit;
  logic shift;
  logic fin_pid;
  logic fin_len;
  logic fin_ok;

  assign pop       = !empty && out_ready;
  assign out_valid = !empty;
  assign data_byte = (state == DATA) && rx_active && rx_valid;

  // Once the delay line is full, every new byte tries to forward the oldest one.
  always_comb begin
    push    = 1'b0;
    len_hit = 1'b0;
    ovf_hit = 1'b0;
    if (data_byte && fill == 2'd2) begin
      if (count == 10'(MAX_LEN))  len_hit = 1'b1;
      else if (full && !pop)      ovf_hit = 1'b1;
      else                        push    = 1'b1;
    end
  end

  assign shift   = data_byte && !len_hit && !ovf_hit;
  assign fin_pid = e_pid || (state == PID);
  assign fin_len = e_len || ((state == DATA) && fill != 2'd2);
  assign fin_ok  = !(fin_pid || fin_len || e_ovf) &&
                   (((state == DATA) && crc == CRC16_RESID) || (state == HSK));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rx_active_d <= 1'b1;
      crc         <= CRC16_INIT;
      fill        <= '0;
      count       <= '0;
      cur_pid     <= '0;
      e_pid       <= 1'b0;
      e_len       <= 1'b0;
      e_ovf       <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_pid     <= '0;
      pkt_len     <= '0;
      crc_ok      <= 1'b0;
      err_pid     <= 1'b0;
      err_len     <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      rx_active_d <= rx_active;
      pkt_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_active && !rx_active_d) begin
            state   <= PID;
            cur_pid <= '0;
            count   <= '0;
            fill    <= '0;
            e_pid   <= 1'b0;
            e_len   <= 1'b0;
            e_ovf   <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (!rx_active) begin
            state    <= DONE;
            pkt_done <= 1'b1;
            pkt_pid  <= cur_pid;
            pkt_len  <= count;
            crc_ok   <= fin_ok;
            err_pid  <= fin_pid;
            err_len  <= fin_len;
            err_ovf  <= e_ovf;
          end else if (rx_valid) begin
            case (state)
              PID: begin
                cur_pid <= rx_data[3:0];
                if (rx_data[3:0] != ~rx_data[7:4]) begin
                  e_pid <= 1'b1;
                  state <= ERR;
                end else if (rx_data[3:0] == PID_DATA0 || rx_data[3:0] == PID_DATA1) begin
                  state <= DATA;
                  crc   <= CRC16_INIT;
                  count <= '0;
                  fill  <= '0;
                end else if (rx_data[3:0] == PID_ACK || rx_data[3:0] == PID_NAK ||
                             rx_data[3:0] == PID_STALL) begin
                  state <= HSK;
                end else begin
                  e_pid <= 1'b1;
                  state <= ERR;
                end
              end
              DATA: begin
                crc <= crc16_byte(crc, rx_data);
                if (len_hit) begin
                  e_len <= 1'b1;
                  state <= ERR;
                end else if (ovf_hit) begin
                  e_ovf <= 1'b1;
                  state <= ERR;
                end else begin
                  if (fill != 2'd2) fill <= fill + 2'd1;
                  if (push) count <= count + 10'd1;
                end
              end
              HSK:     e_len <= 1'b1;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Two-byte delay line holds back the trailing CRC bytes.
  always_ff @(posedge clk) begin
    if (shift) begin
      d1 <= d0;
      d0 <= rx_data;
    end
  end

  usb_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_W    (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(d1),
    .pop      (pop),
    .rd_data  (out_data),
    .full     (full),
    .empty    (empty)
  );

`ifdef USB_RX_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (pkt_done) begin
      if (crc_ok) good_cnt <= sat_inc(good_cnt);
      else        bad_cnt  <= sat_inc(bad_cnt);
    end
  end
`endif

endmodule
